// File: rtl/subtractor_32bit_pipe_pkg.sv
// Shared widths, lookahead group size and result record for the pipelined subtractor.
// Combinational definitions only; no latency.
// No handshake of its own.
package subtractor_32bit_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;
    localparam int GRP_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              b32;
        logic              v;
    } res_t;

    function automatic int num_groups(input int n);
        return (n + GRP_W - 1) / GRP_W;
    endfunction

endpackage

// File: rtl/subtractor_32bit_pipe_sub_half_bla.sv
// Half-width subtractor x - y - bin built as x + ~y + ~bin with 4-bit group borrow-lookahead.
// Purely combinational, zero cycles.
// No handshake; the enclosing pipeline stage owns flow control.
module sub_half_bla
    import subtractor_32bit_pipe_pkg::*;
#(
    parameter int N = HALF_W
) (
    input  logic [N-1:0]               x,
    input  logic [N-1:0]               y,
    input  logic                       bin,
    output logic [N-1:0]               d,
    output logic                       bout,
    output logic [num_groups(N)-1:0]   grp_p,
    output logic [num_groups(N)-1:0]   grp_g
);

    localparam int NG = num_groups(N);
    localparam int NP = NG * GRP_W;

    always_comb begin : bla
        logic [NP-1:0] xe;
        logic [NP-1:0] yn;
        logic [NP-1:0] g;
        logic [NP-1:0] p;
        logic [NP-1:0] c;
        logic [NG-1:0] gg;
        logic [NG-1:0] gp;
        logic [NG:0]   gc;

        // Padding bits are x=0, ~y=1: they propagate, so the top carry is unchanged.
        xe         = '0;
        yn         = '1;
        xe[N-1:0]  = x;
        yn[N-1:0]  = ~y;
        g          = xe & yn;
        p          = xe ^ yn;
        c          = '0;
        gg         = '0;
        gp         = '1;
        gc         = '0;
        gc[0]      = ~bin;

        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GRP_W; j++) begin
                gg[k] = g[k*GRP_W+j] | (p[k*GRP_W+j] & gg[k]);
                gp[k] = gp[k] & p[k*GRP_W+j];
            end
            gc[k+1]    = gg[k] | (gp[k] & gc[k]);
            c[k*GRP_W] = gc[k];
            for (int j = 1; j < GRP_W; j++) begin
                c[k*GRP_W+j] = g[k*GRP_W+j-1] | (p[k*GRP_W+j-1] & c[k*GRP_W+j-1]);
            end
        end

        d     = p[N-1:0] ^ c[N-1:0];
        bout  = ~gc[NG];
        grp_p = gp;
        grp_g = gg;
    end

endmodule

// File: rtl/subtractor_32bit_pipe.sv
// Two-stage pipelined D = A - B with borrow-out and signed-overflow flags; low half in S1, high half in S2.
// Latency: result valid one edge after the S2 load, i.e. on the second edge counting the accept edge.
// Backpressure: stages advance on ~valid | downstream-advance; in_ready follows out_ready combinationally.
module subtractor_32bit_pipe
    import subtractor_32bit_pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] D,
    output logic             B32,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int HW = WIDTH / 2;
    localparam int NG = num_groups(HW);

    logic s1_valid_q, s1_valid_d;
    logic [HW-1:0] d_lo_q, d_lo_d;
    logic b_mid_q, b_mid_d;
    logic [HW-1:0] a_hi_q, a_hi_d;
    logic [HW-1:0] b_hi_q, b_hi_d;

    logic s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic b32_q, b32_d;
    logic v_q, v_d;

    logic s1_adv, s2_adv;
    logic [HW-1:0] d_lo, d_hi;
    logic b_mid, b_out_hi;
    logic [NG-1:0] s1_grp_p_unused, s1_grp_g_unused;
    logic [NG-1:0] s2_grp_p_unused, s2_grp_g_unused;

    sub_half_bla #(.N(HW)) u_s1_half (
        .x     (A[HW-1:0]),
        .y     (B[HW-1:0]),
        .bin   (1'b0),
        .d     (d_lo),
        .bout  (b_mid),
        .grp_p (s1_grp_p_unused),
        .grp_g (s1_grp_g_unused)
    );

    sub_half_bla #(.N(HW)) u_s2_half (
        .x     (a_hi_q),
        .y     (b_hi_q),
        .bin   (b_mid_q),
        .d     (d_hi),
        .bout  (b_out_hi),
        .grp_p (s2_grp_p_unused),
        .grp_g (s2_grp_g_unused)
    );

    always_comb begin
        s2_adv     = ~s2_valid_q | out_ready;
        s1_adv     = ~s1_valid_q | s2_adv;

        s1_valid_d = s1_valid_q;
        d_lo_d     = d_lo_q;
        b_mid_d    = b_mid_q;
        a_hi_d     = a_hi_q;
        b_hi_d     = b_hi_q;
        s2_valid_d = s2_valid_q;
        d_d        = d_q;
        b32_d      = b32_q;
        v_d        = v_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                d_lo_d  = d_lo;
                b_mid_d = b_mid;
                a_hi_d  = A[WIDTH-1:HW];
                b_hi_d  = B[WIDTH-1:HW];
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d   = {d_hi, d_lo_q};
                b32_d = b_out_hi;
                // Overflow only when operand signs differ and the result sign leaves A's.
                v_d   = (a_hi_q[HW-1] ^ b_hi_q[HW-1]) & (d_hi[HW-1] ^ a_hi_q[HW-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            d_lo_q     <= '0;
            b_mid_q    <= 1'b0;
            a_hi_q     <= '0;
            b_hi_q     <= '0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            b32_q      <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            d_lo_q     <= d_lo_d;
            b_mid_q    <= b_mid_d;
            a_hi_q     <= a_hi_d;
            b_hi_q     <= b_hi_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            b32_q      <= b32_d;
            v_q        <= v_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign D         = d_q;
    assign B32       = b32_q;
    assign V         = v_q;

endmodule

// File: tb/tb_subtractor_32bit_pipe.sv
// Scoreboard bench for subtractor_32bit_pipe: directed corner cases, backpressure, async reset, random traffic.
module tb_subtractor_32bit_pipe;
    import subtractor_32bit_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic        in_valid, in_ready;
    logic [31:0] D;
    logic        B32, V, out_valid, out_ready;

    res_t exp_q[$];
    res_t mon_exp;
    res_t held;
    logic stall_seen = 1'b0;
    logic rnd_on = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    subtractor_32bit_pipe #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .B32       (B32),
        .V         (V),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Reference: wide signed/unsigned arithmetic, no bit-level structure.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        longint sa, sb, diff;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        diff  = sa - sb;
        r.d   = a - b;
        r.b32 = (a < b);
        r.v   = (diff > longint'(32'h7FFF_FFFF)) || (diff < -longint'(32'h8000_0000));
        return r;
    endfunction

    function automatic res_t mk(input logic [31:0] d, input logic b, input logic v);
        res_t r;
        r.d   = d;
        r.b32 = b;
        r.v   = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per output handshake and checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen) check("hold_while_stalled", {D, B32, V}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual D=%h B32=%b V=%b required none", D, B32, V);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("result", {D, B32, V}, mon_exp);
                end
            end
            stall_seen = out_valid && !out_ready;
            held       = {D, B32, V};
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input res_t e, input bit track);
        bit done;
        done     = 1'b0;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                if (track) exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual in_ready=0 for 200 cycles required 1");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (exp_q.size() != 0 && t < 1000);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        A         = '0;
        B         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset_outputs", {out_valid, D, B32, V}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("in_ready_after_reset", in_ready, 1);
        out_ready = 1'b1;

        // Latency: 5 - 3 captured at the first edge, visible after the second.
        A        = 32'd5;
        B        = 32'd3;
        in_valid = 1'b1;
        exp_q.push_back(mk(32'd2, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("latency_edge1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_edge2_out_valid", out_valid, 1);
        check("latency_D", D, 32'd2);

        send(32'h0000_0000, 32'h0000_0001, mk(32'hFFFF_FFFF, 1'b1, 1'b0), 1);
        send(32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 1'b0, 1'b1), 1);
        send(32'h0001_0000, 32'h0000_0001, mk(32'h0000_FFFF, 1'b0, 1'b0), 1);
        send(32'h0000_0000, 32'h0001_0000, mk(32'hFFFF_0000, 1'b1, 1'b0), 1);
        send(32'h1234_5678, 32'h1234_5678, mk(32'h0000_0000, 1'b0, 1'b0), 1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, mk(32'h8000_0000, 1'b1, 1'b1), 1);
        drain();

        // Backpressure: out_ready low for five edges while four ops stream in.
        fork
            begin
                send(32'd10, 32'd1, mk(32'd9,  1'b0, 1'b0), 1);
                send(32'd20, 32'd2, mk(32'd18, 1'b0, 1'b0), 1);
                send(32'd30, 32'd3, mk(32'd27, 1'b0, 1'b0), 1);
                send(32'd40, 32'd4, mk(32'd36, 1'b0, 1'b0), 1);
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(posedge clk);
                @(posedge clk);
                #2;
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_D", D, 32'd9);
                @(posedge clk);
                #2;
                check("stall_D_held", D, 32'd9);
                @(posedge clk);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with both stages occupied.
        out_ready = 1'b0;
        send(32'd100, 32'd1, mk(32'd99, 1'b0, 1'b0), 0);
        send(32'd200, 32'd1, mk(32'd199, 1'b0, 1'b0), 0);
        check("full_pipe_ready_valid", {in_ready, out_valid}, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {out_valid, D, B32, V}, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("in_ready_after_mid_reset", in_ready, 1);
        out_ready = 1'b1;
        send(32'd7, 32'd7, mk(32'd0, 1'b0, 1'b0), 1);
        check("post_reset_edge1_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("post_reset_edge2_out_valid", out_valid, 1);
        check("post_reset_D_B32", {D, B32}, 0);
        drain();

        // Random traffic with random gaps and random downstream stalls.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [31:0] ra, rb;
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = $urandom;
                    rb = $urandom;
                    case ($urandom_range(7))
                        0: rb = ra;
                        1: ra = 32'h8000_0000;
                        2: rb = 32'hFFFF_FFFF;
                        3: rb = {ra[31:16], rb[15:0]};
                        default: ;
                    endcase
                    send(ra, rb, model(ra, rb), 1);
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
